// File: rtl/fetch_trace_buffer_if.sv
// Signal bundle between the CPU tap / debug readout path and the fetch trace buffer.
// rd_pc/rd_halt/rd_valid answer the rd_addr presented one cycle earlier; rd_valid=0 forces rd_pc/rd_halt to 0.
interface fetch_trace_buffer_if #(
    parameter int PC_W  = 9,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
);
    localparam int AW = $clog2(DEPTH);

    logic            in_if1;
    logic [PC_W-1:0] pc_in;
    logic            halt;
    logic            clear;
    logic [AW-1:0]   rd_addr;
    logic [PC_W-1:0] rd_pc;
    logic            rd_halt;
    logic            rd_valid;
    logic [AW:0]     count;
    logic [CNT_W-1:0] total;
    logic            overflow;
    logic            frozen;
    logic [1:0]      dbg_state;

    modport master (
        output in_if1, pc_in, halt, clear, rd_addr,
        input  rd_pc, rd_halt, rd_valid, count, total, overflow, frozen, dbg_state
    );

    modport slave (
        input  in_if1, pc_in, halt, clear, rd_addr,
        output rd_pc, rd_halt, rd_valid, count, total, overflow, frozen, dbg_state
    );
endinterface

// File: rtl/fetch_trace_buffer.sv
// Circular trace of fetch PCs plus halt records, with optional freeze-on-halt
// so the history survives for readout over the switch/HEX debug path.
module fetch_trace_buffer #(
    parameter int PC_W        = 9,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 16,
    parameter bit HALT_FREEZE = 1'b1
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    fetch_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             in_if1_q, halt_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic             overflow_q, overflow_d;
    logic [PC_W-1:0]  rd_pc_q, rd_pc_d;
    logic             rd_halt_q, rd_halt_d;
    logic             rd_valid_q, rd_valid_d;

    // Entry layout: {halt_flag, pc}
    logic [PC_W:0]    trace_mem_q [DEPTH];
    logic             mem_we;
    logic [PC_W:0]    mem_wdata;

    logic             fetch_ev, halt_ev;
    logic [AW-1:0]    rd_idx;
    logic [PC_W:0]    rd_entry;

    assign fetch_ev = bus.in_if1 & ~in_if1_q;
    assign halt_ev  = bus.halt & ~halt_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        total_d    = total_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        mem_wdata  = {halt_ev, bus.pc_in};

        if (bus.clear) begin
            state_d    = IDLE;
            wr_ptr_d   = '0;
            count_d    = '0;
            total_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, RUN: begin
                    if (fetch_ev || halt_ev) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        if (count_q == FULL) begin
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + (AW+1)'(1);
                        end
                        if (fetch_ev && (total_q != '1)) begin
                            total_d = total_q + CNT_W'(1);
                        end
                        state_d = (halt_ev && HALT_FREEZE) ? FROZEN : RUN;
                    end
                end
                default: begin
                    state_d = FROZEN;
                end
            endcase
        end
    end

    // Lookup uses pre-write pointer/count, so a same-slot write returns old contents.
    always_comb begin
        rd_idx     = wr_ptr_q - count_q[AW-1:0] + bus.rd_addr;
        rd_entry   = trace_mem_q[rd_idx];
        rd_valid_d = ({1'b0, bus.rd_addr} < count_q);
        rd_pc_d    = rd_valid_d ? rd_entry[PC_W-1:0] : '0;
        rd_halt_d  = rd_valid_d ? rd_entry[PC_W] : 1'b0;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            in_if1_q   <= 1'b0;
            halt_q     <= 1'b0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            total_q    <= '0;
            overflow_q <= 1'b0;
            rd_pc_q    <= '0;
            rd_halt_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_if1_q   <= bus.in_if1;
            halt_q     <= bus.halt;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            total_q    <= total_d;
            overflow_q <= overflow_d;
            rd_pc_q    <= rd_pc_d;
            rd_halt_q  <= rd_halt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (mem_we) begin
            trace_mem_q[wr_ptr_q] <= mem_wdata;
        end
    end

    assign bus.rd_pc     = rd_pc_q;
    assign bus.rd_halt   = rd_halt_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.count     = count_q;
    assign bus.total     = total_q;
    assign bus.overflow  = overflow_q;
    assign bus.frozen    = (state_q == FROZEN);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_fetch_trace_buffer.sv
// Drives two trace buffers (DEPTH=4 freeze-on-halt, DEPTH=8 keep-running with a 3-bit total)
// with shared stimulus and compares each against a queue-based reference.
module tb_fetch_trace_buffer;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    fetch_trace_buffer_if #(.PC_W(9), .DEPTH(4), .CNT_W(16)) ifa ();
    fetch_trace_buffer_if #(.PC_W(9), .DEPTH(8), .CNT_W(3))  ifb ();

    fetch_trace_buffer #(.PC_W(9), .DEPTH(4), .CNT_W(16), .HALT_FREEZE(1'b1)) dut_a (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (ifa)
    );

    fetch_trace_buffer #(.PC_W(9), .DEPTH(8), .CNT_W(3), .HALT_FREEZE(1'b0)) dut_b (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (ifb)
    );

    int checks = 0;
    int errors = 0;

    // Shared stimulus
    bit         s_if1, s_halt, s_clear;
    logic [8:0] s_pc;
    int         s_ra;

    // Reference model: per-instance queue of {halt, pc}, oldest at the front
    logic [9:0] exp_q [2][$];
    int         exp_total [2];
    bit         exp_ovf [2], exp_frz [2], prev_if1 [2], prev_halt [2];
    logic [8:0] exp_rpc [2];
    bit         exp_rh [2], exp_rv [2];
    int         dep  [2] = '{4, 8};
    bit         hf   [2] = '{1'b1, 1'b0};
    int         tmax [2] = '{65535, 7};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            exp_q[k].delete();
            exp_total[k] = 0;
            exp_ovf[k]   = 1'b0;
            exp_frz[k]   = 1'b0;
            prev_if1[k]  = 1'b0;
            prev_halt[k] = 1'b0;
            exp_rpc[k]   = '0;
            exp_rh[k]    = 1'b0;
            exp_rv[k]    = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        bit fe, he;
        int a;
        logic [9:0] e;
        a = s_ra % dep[k];
        if (a < exp_q[k].size()) begin
            e          = exp_q[k][a];
            exp_rv[k]  = 1'b1;
            exp_rpc[k] = e[8:0];
            exp_rh[k]  = e[9];
        end else begin
            exp_rv[k]  = 1'b0;
            exp_rpc[k] = '0;
            exp_rh[k]  = 1'b0;
        end
        fe = s_if1 && !prev_if1[k];
        he = s_halt && !prev_halt[k];
        prev_if1[k]  = s_if1;
        prev_halt[k] = s_halt;
        if (s_clear) begin
            exp_q[k].delete();
            exp_total[k] = 0;
            exp_ovf[k]   = 1'b0;
            exp_frz[k]   = 1'b0;
        end else if (!exp_frz[k] && (fe || he)) begin
            if (exp_q[k].size() == dep[k]) begin
                exp_ovf[k] = 1'b1;
                void'(exp_q[k].pop_front());
            end
            exp_q[k].push_back({he, s_pc});
            if (fe && exp_total[k] < tmax[k]) exp_total[k]++;
            if (he && hf[k]) exp_frz[k] = 1'b1;
        end
    endtask

    task automatic apply();
        ifa.in_if1  = s_if1;  ifb.in_if1  = s_if1;
        ifa.halt    = s_halt; ifb.halt    = s_halt;
        ifa.clear   = s_clear; ifb.clear  = s_clear;
        ifa.pc_in   = s_pc;   ifb.pc_in   = s_pc;
        ifa.rd_addr = 2'(s_ra);
        ifb.rd_addr = 3'(s_ra);
    endtask

    task automatic check_all();
        chk("a_count",    ifa.count,    exp_q[0].size());
        chk("a_total",    ifa.total,    exp_total[0]);
        chk("a_overflow", ifa.overflow, exp_ovf[0]);
        chk("a_frozen",   ifa.frozen,   exp_frz[0]);
        chk("a_rd_valid", ifa.rd_valid, exp_rv[0]);
        chk("a_rd_pc",    ifa.rd_pc,    exp_rpc[0]);
        chk("a_rd_halt",  ifa.rd_halt,  exp_rh[0]);
        chk("b_count",    ifb.count,    exp_q[1].size());
        chk("b_total",    ifb.total,    exp_total[1]);
        chk("b_overflow", ifb.overflow, exp_ovf[1]);
        chk("b_frozen",   ifb.frozen,   exp_frz[1]);
        chk("b_rd_valid", ifb.rd_valid, exp_rv[1]);
        chk("b_rd_pc",    ifb.rd_pc,    exp_rpc[1]);
        chk("b_rd_halt",  ifb.rd_halt,  exp_rh[1]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a_count"}, ifa.count, 0);
        chk({tag, "_a_total"}, ifa.total, 0);
        chk({tag, "_a_ovf"},   ifa.overflow, 0);
        chk({tag, "_a_frz"},   ifa.frozen, 0);
        chk({tag, "_a_rd"},    {ifa.rd_valid, ifa.rd_halt, ifa.rd_pc}, 0);
        chk({tag, "_b_count"}, ifb.count, 0);
        chk({tag, "_b_total"}, ifb.total, 0);
        chk({tag, "_b_ovf"},   ifb.overflow, 0);
        chk({tag, "_b_frz"},   ifb.frozen, 0);
        chk({tag, "_b_rd"},    {ifb.rd_valid, ifb.rd_halt, ifb.rd_pc}, 0);
    endtask

    // One clock: present stimulus, advance the model, compare #1 after the edge
    task automatic cycle();
        apply();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic fetch(input logic [8:0] pc);
        s_if1 = 1'b1; s_pc = pc; cycle();
        s_if1 = 1'b0; cycle();
    endtask

    task automatic do_clear();
        s_clear = 1'b1; cycle();
        s_clear = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        s_if1 = 0; s_halt = 0; s_clear = 0; s_pc = '0; s_ra = 0;
        apply();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;

        // Three fetches, then read back every slot of the DEPTH=4 trace
        fetch(9'd0); fetch(9'd1); fetch(9'd2);
        chk("p1_count", ifa.count, 3);
        chk("p1_total", ifa.total, 3);
        for (int ra = 0; ra < 4; ra++) begin
            s_ra = ra; cycle();
            chk("p1_rd_valid", ifa.rd_valid, (ra < 3) ? 1 : 0);
            chk("p1_rd_pc",    ifa.rd_pc,    (ra < 3) ? ra : 0);
            chk("p1_rd_halt",  ifa.rd_halt,  0);
        end

        // Wrap-around: six fetches into four slots
        do_clear();
        for (int i = 0; i < 6; i++) fetch(9'(i));
        chk("p2_count", ifa.count, 4);
        chk("p2_ovf",   ifa.overflow, 1);
        chk("p2_total", ifa.total, 6);
        for (int ra = 0; ra < 4; ra++) begin
            s_ra = ra; cycle();
            chk("p2_rd_pc", ifa.rd_pc, ra + 2);
        end

        // Halt record, freeze on A, keep running on B
        do_clear();
        fetch(9'd0); fetch(9'd1);
        s_halt = 1'b1; s_pc = 9'd7; cycle();
        chk("p3_frozen", ifa.frozen, 1);
        fetch(9'd3); fetch(9'd4);
        chk("p3_count", ifa.count, 3);
        chk("p3_total", ifa.total, 2);
        chk("p5_b_count",  ifb.count, 5);
        chk("p5_b_frozen", ifb.frozen, 0);
        s_ra = 2; cycle();
        chk("p3_rd_halt", ifa.rd_halt, 1);
        chk("p3_rd_pc",   ifa.rd_pc, 7);
        s_halt = 1'b0; cycle();

        // Clear wins over a simultaneous fetch edge while frozen
        s_clear = 1'b1; s_if1 = 1'b1; s_pc = 9'h1AA; cycle();
        s_clear = 1'b0; s_if1 = 1'b0;
        chk("p6_count", ifa.count, 0);
        chk("p6_total", ifa.total, 0);
        chk("p6_frozen", ifa.frozen, 0);
        cycle();
        fetch(9'h055);
        s_ra = 0; cycle();
        chk("p6_rd_pc", ifa.rd_pc, 9'h055);

        // Fetch and halt edges together make one halt entry
        do_clear();
        s_if1 = 1'b1; s_halt = 1'b1; s_pc = 9'h019; cycle();
        s_if1 = 1'b0; s_halt = 1'b0; cycle();
        chk("p4_count",  ifa.count, 1);
        chk("p4_total",  ifa.total, 1);
        chk("p4_frozen", ifa.frozen, 1);
        s_ra = 0; cycle();
        chk("p4_rd_pc",   ifa.rd_pc, 9'h019);
        chk("p4_rd_halt", ifa.rd_halt, 1);

        // Randomized traffic
        repeat (500) begin
            s_if1   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) s_halt = ~s_halt;
            s_clear = ($urandom_range(0, 39) == 0);
            s_pc    = 9'($urandom_range(0, 511));
            s_ra    = $urandom_range(0, 7);
            cycle();
        end

        // Asynchronous reset in the middle of activity
        s_clear = 1'b0; s_halt = 1'b0;
        do_clear();
        fetch(9'h101); fetch(9'h102);
        s_ra = 0; cycle();
        #2 reset_n = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        s_if1 = 1'b1; s_pc = 9'h0AB; apply();
        @(posedge clk);
        #1 reset_n = 1'b1;
        // in_if1 already high after reset counts as a fetch edge
        cycle();
        chk("rst_edge_count", ifa.count, 1);
        s_if1 = 1'b0; s_ra = 0; cycle();
        chk("rst_edge_rd_pc", ifa.rd_pc, 9'h0AB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_trace_buffer.md
Name: fetch_trace_buffer

Overview:
- Synthesizable debug block for the RISC machine. Records the PC at every instruction fetch into a circular trace memory of parametrised depth, and logs the final PC when the CPU halts.
- Optionally freezes on halt so the trace survives for readout.
- Sits beside the CPU in the top-level. Taps the CPU's "in IF1" indication, PC and halt (LEDR[8]) signals. Readout goes to a switch/HEX debug path.

Parameters:
- PC_W, 9: PC width in bits.
- DEPTH, 16: trace entries; must be a power of 2, minimum 2.
- CNT_W, 16: width of the total-fetch counter.
- HALT_FREEZE, 1: 1 = stop capturing after the halt entry; 0 = log the halt entry and keep running.

Ports:
- CLOCK_50, input, 1: system clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset (driven from KEY[1]).
- in_if1, input, 1: high while the CPU FSM is in IF1 (level).
- pc_in, input, PC_W: current CPU PC.
- halt, input, 1: CPU halted (level).
- clear, input, 1: synchronous clear of trace and counters.
- rd_addr, input, log2(DEPTH): readout index; 0 = oldest valid entry.
- rd_pc, output, PC_W: PC of the addressed entry (registered).
- rd_halt, output, 1: addressed entry was a halt record (registered).
- rd_valid, output, 1: rd_addr < count (registered, aligned with rd_pc).
- count, output, log2(DEPTH)+1: valid entries, saturates at DEPTH.
- total, output, CNT_W: fetch edges logged since reset/clear, saturating at all-ones.
- overflow, output, 1: at least one entry has been overwritten.
- frozen, output, 1: state == FROZEN.

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0, wr_ptr=0, state=IDLE, edge-detect registers for in_if1 and halt = 0. Trace memory contents are don't-care.
- Edge detection: fetch_ev = in_if1 & ~in_if1_q; halt_ev = halt & ~halt_q.
  - Both _q registers update every cycle in all states.
  - A level already high on the first cycle after reset counts as an edge.
- Event handling: an event (fetch_ev or halt_ev) writes entry {halt_flag = halt_ev, pc_in} at wr_ptr.
  - wr_ptr increments mod DEPTH.
  - count increments, saturating at DEPTH.
  - If count == DEPTH before the write, overflow is set (sticky).
  - Simultaneous fetch_ev and halt_ev write exactly one entry, with halt_flag=1.
  - total increments on fetch_ev only, saturating.
- States:
  - IDLE: no entries yet. Any event writes and moves to RUN, or to FROZEN if halt_ev and HALT_FREEZE=1.
  - RUN: events write. On halt_ev with HALT_FREEZE=1, go to FROZEN after writing.
  - FROZEN: no writes, count/total/overflow held, edge registers keep tracking. Leaves only via clear (to IDLE) or reset.
- Clear (synchronous, any state): wr_ptr, count, total, overflow = 0; state = IDLE. Events in the same cycle are dropped, since clear has priority.
- Readout:
  - Physical index = (wr_ptr - count + rd_addr) mod DEPTH.
  - rd_pc, rd_halt and rd_valid register this lookup, so they reflect the rd_addr presented one cycle earlier.
  - When rd_valid=0, rd_pc=0 and rd_halt=0.
  - A read and a write to the same physical slot in one cycle return the old contents.
- Width rules: the pointer wraps naturally at log2(DEPTH) bits. count is one bit wider so it can hold DEPTH.
- Reset asserted mid-run: immediate return to reset values; no partial entry is guaranteed.

Test Plan:
1. DEPTH=4. Reset, then pulse in_if1 3 times with pc_in=0,1,2 -> count=3, total=3, rd_addr 0..2 return PC 0,1,2 with rd_halt=0; rd_addr=3 gives rd_valid=0.
2. DEPTH=4. Six fetches with PC 0..5 -> count=4, overflow=1, total=6; rd_addr 0..3 return PC 2,3,4,5.
3. HALT_FREEZE=1. Fetches PC 0,1, then halt rises with pc_in=7 -> entry 2 = {halt=1, 7}, frozen=1; further in_if1 pulses leave count=3, total=2.
4. in_if1 and halt rise in the same cycle with pc_in=0x19 -> exactly one entry {1, 0x19}, total +1, frozen=1.
5. HALT_FREEZE=0. Halt event -> entry logged, state stays RUN, subsequent fetches still recorded.
6. Assert clear in the same cycle as a fetch edge while FROZEN -> count=0, total=0, overflow=0, frozen=0; next fetch writes at rd_addr 0. Asserting reset_n=0 mid-stream zeroes all outputs immediately, without waiting for a clock edge.
